// File: rtl/ctrl_pkg.sv
// ctrl_pkg: encodings shared by the multicycle controller and its datapath
// (FSM states, instruction classes, opcodes, immediate formats, write-back sources).
package ctrl_pkg;
    typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, ERR} state_t;
    typedef enum logic [3:0] {
        C_OP, C_OPIMM, C_LOAD, C_STORE, C_BRANCH, C_LUI, C_AUIPC, C_JAL, C_JALR, C_ILL
    } cls_t;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_U = 3'b011;
    localparam logic [2:0] IMM_J = 3'b100;
    localparam logic [1:0] WB_ALU = 2'b00;
    localparam logic [1:0] WB_MEM = 2'b01;
    localparam logic [1:0] WB_PC4 = 2'b10;
    localparam logic [1:0] WB_IMM = 2'b11;
    localparam logic [31:0] IR_RESET = 32'h0000_0013;
endpackage

// File: rtl/opcode_decode.sv
// opcode_decode: maps an opcode to its instruction class, immediate format and legality.
module opcode_decode
    import ctrl_pkg::*;
(
    input  logic [6:0] opcode,
    output logic [3:0] cls,
    output logic [2:0] sel_imm,
    output logic       legal
);
    always_comb begin
        cls = C_ILL;
        sel_imm = IMM_I;
        legal = 1'b1;
        case (opcode)
            OPC_OP:     cls = C_OP;
            OPC_OPIMM:  cls = C_OPIMM;
            OPC_LOAD:   cls = C_LOAD;
            OPC_JALR:   cls = C_JALR;
            OPC_STORE:  begin cls = C_STORE;  sel_imm = IMM_S; end
            OPC_BRANCH: begin cls = C_BRANCH; sel_imm = IMM_B; end
            OPC_LUI:    begin cls = C_LUI;    sel_imm = IMM_U; end
            OPC_AUIPC:  begin cls = C_AUIPC;  sel_imm = IMM_U; end
            OPC_JAL:    begin cls = C_JAL;    sel_imm = IMM_J; end
            default:    legal = 1'b0;
        endcase
    end
endmodule

// File: rtl/multicycle_controller.sv
// multicycle_controller: FETCH/DECODE/EXEC/MEM/WB control FSM with a memory wait timeout.
// Define ILLEGAL_TRAP_EN to trap unlisted opcodes into ERR; otherwise they retire as NOPs.
module multicycle_controller
    import ctrl_pkg::*;
#(
    parameter int MAX_WAIT = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready,
    input  logic        br_taken,
    output logic        mem_req,
    output logic        mem_we,
    output logic        addr_sel,
    output logic [31:0] ir,
    output logic [2:0]  sel_imm,
    output logic        alu_a_sel,
    output logic        alu_b_sel,
    output logic        alu_add,
    output logic        rf_we,
    output logic [1:0]  wb_sel,
    output logic        pc_we,
    output logic        pc_sel,
    output logic        bus_err,
    output logic        illegal
);
    localparam int WW = $clog2(MAX_WAIT + 1);
    state_t state_q, state_d;
    logic [31:0] ir_q, ir_d;
    logic [WW-1:0] wait_q, wait_d;
    logic bus_err_q, bus_err_d;
    logic [3:0] cls;
    logic [2:0] dec_imm;
    logic legal, trap, waiting, timeout, ex, wb;
    opcode_decode u_dec (
        .opcode (ir_q[6:0]),
        .cls    (cls),
        .sel_imm(dec_imm),
        .legal  (legal)
    );
`ifdef ILLEGAL_TRAP_EN
    logic illegal_q;
    assign trap = !legal;
    assign illegal = illegal_q;
`else
    assign trap = 1'b0;
    assign illegal = 1'b0;
`endif
    assign waiting = state_q == FETCH || state_q == MEM;
    // A ready arriving on the last allowed cycle still completes the access
    assign timeout = waiting && !mem_ready && wait_q == WW'(MAX_WAIT - 1);
    assign ex = state_q == EXEC;
    assign wb = state_q == WB;
    always_comb begin
        state_d = state_q;
        ir_d = ir_q;
        wait_d = (waiting && !mem_ready) ? wait_q + 1'b1 : '0;
        bus_err_d = bus_err_q | timeout;
        if (timeout) state_d = ERR;
        else begin
            case (state_q)
                FETCH: if (mem_ready) begin
                    ir_d = mem_rdata;
                    state_d = DECODE;
                end
                DECODE: state_d = trap ? ERR : EXEC;
                EXEC: state_d = cls == C_BRANCH ? FETCH : (cls inside {C_LOAD, C_STORE} ? MEM : WB);
                MEM: if (mem_ready) state_d = cls == C_STORE ? FETCH : WB;
                WB: state_d = FETCH;
                default: state_d = state_q;
            endcase
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= FETCH;
            ir_q <= IR_RESET;
            wait_q <= '0;
            bus_err_q <= 1'b0;
`ifdef ILLEGAL_TRAP_EN
            illegal_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            ir_q <= ir_d;
            wait_q <= wait_d;
            bus_err_q <= bus_err_d;
`ifdef ILLEGAL_TRAP_EN
            illegal_q <= illegal_q | (state_q == DECODE && trap);
`endif
        end
    end
    // mem_req is gated by rst_n so an access is dropped the moment reset asserts
    assign mem_req = rst_n && waiting;
    assign mem_we = state_q == MEM && cls == C_STORE;
    assign addr_sel = state_q == MEM;
    assign ir = ir_q;
    assign sel_imm = state_q == DECODE ? dec_imm : IMM_I;
    assign alu_a_sel = ex && cls inside {C_AUIPC, C_JAL, C_BRANCH};
    assign alu_b_sel = ex && !(cls inside {C_OP, C_LUI, C_ILL});
    assign alu_add = ex && cls inside {C_JAL, C_JALR, C_AUIPC, C_LOAD, C_STORE};
    assign rf_we = wb && legal;
    assign wb_sel = !wb ? WB_ALU : cls == C_LOAD ? WB_MEM :
                    cls inside {C_JAL, C_JALR} ? WB_PC4 : cls == C_LUI ? WB_IMM : WB_ALU;
    assign pc_we = (ex && cls == C_BRANCH) || (state_q == MEM && cls == C_STORE && mem_ready) || wb;
    assign pc_sel = (ex && cls == C_BRANCH) ? br_taken : wb && cls inside {C_JAL, C_JALR};
    assign bus_err = bus_err_q;
endmodule

// File: tb/tb_multicycle_controller.sv
// tb_multicycle_controller: directed per-cycle vectors queued into a scoreboard that a
// separate monitor checks against the DUT control outputs each cycle.
module tb_multicycle_controller;
    logic clk = 1'b0, rst_n = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic mem_ready = 1'b0, br_taken = 1'b0;
    logic mem_req, mem_we, addr_sel, alu_a_sel, alu_b_sel, alu_add, rf_we, pc_we, pc_sel, bus_err, illegal;
    logic [31:0] ir;
    logic [2:0] sel_imm;
    logic [1:0] wb_sel;
    logic [15:0] ctl;
    int cyc = 0, n_cmp = 0, n_bad = 0;
    localparam logic [15:0] REQ = 16'h8000, WE = 16'h4000, AS = 16'h2000;
    localparam logic [15:0] S_S = 16'h0400, S_B = 16'h0800, S_U = 16'h0C00, S_J = 16'h1000;
    localparam logic [15:0] AA = 16'h0200, AB = 16'h0100, ADD = 16'h0080, RF = 16'h0040;
    localparam logic [15:0] W_MEM = 16'h0010, W_PC4 = 16'h0020, W_IMM = 16'h0030;
    localparam logic [15:0] PW = 16'h0008, PS = 16'h0004, BE = 16'h0002, IL = 16'h0001;
    typedef struct {
        string nm;
        int cyc;
        logic [15:0] e;
        logic ci;
        logic [31:0] ei;
    } exp_t;
    exp_t sb[$];

    multicycle_controller #(.MAX_WAIT(16)) dut (
        .clk(clk), .rst_n(rst_n), .mem_rdata(mem_rdata), .mem_ready(mem_ready), .br_taken(br_taken),
        .mem_req(mem_req), .mem_we(mem_we), .addr_sel(addr_sel), .ir(ir), .sel_imm(sel_imm),
        .alu_a_sel(alu_a_sel), .alu_b_sel(alu_b_sel), .alu_add(alu_add), .rf_we(rf_we),
        .wb_sel(wb_sel), .pc_we(pc_we), .pc_sel(pc_sel), .bus_err(bus_err), .illegal(illegal)
    );
    assign ctl = {mem_req, mem_we, addr_sel, sel_imm, alu_a_sel, alu_b_sel, alu_add, rf_we,
                  wb_sel, pc_we, pc_sel, bus_err, illegal};

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog got time limit exp finish");
        $fatal(1, "watchdog");
    end

    // monitor: pops every expectation queued for the current cycle
    initial begin
        exp_t r;
        forever begin
            @(negedge clk);
            while (sb.size() > 0 && sb[0].cyc == cyc) begin
                r = sb.pop_front();
                n_cmp++;
                if (ctl !== r.e) begin
                    n_bad++;
                    $display("FAIL %s cyc=%0d ctl got %h exp %h", r.nm, r.cyc, ctl, r.e);
                end
                if (r.ci) begin
                    n_cmp++;
                    if (ir !== r.ei) begin
                        n_bad++;
                        $display("FAIL %s cyc=%0d ir got %h exp %h", r.nm, r.cyc, ir, r.ei);
                    end
                end
            end
        end
    end

    task automatic step(input string nm, input logic [15:0] e, input logic rdy = 1'b0,
                        input logic [31:0] rd = 32'h0, input logic br = 1'b0,
                        input logic ci = 1'b0, input logic [31:0] ei = 32'h0);
        mem_ready = rdy;
        mem_rdata = rd;
        br_taken = br;
        sb.push_back('{nm, cyc, e, ci, ei});
        @(posedge clk);
        #1;
    endtask

    initial begin
        @(posedge clk);
        #1;
        step("reset", 16'h0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h13);
        rst_n = 1'b1;
        // ADDI x1, x0, 5
        step("addi_fetch", REQ, 1'b1, 32'h00500093, 1'b0, 1'b1, 32'h13);
        step("addi_decode", 16'h0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h00500093);
        step("addi_exec", AB);
        step("addi_wb", RF | PW);
        // SW with one wait state in MEM
        step("sw_fetch", REQ, 1'b1, 32'h00112223);
        step("sw_decode", S_S, 1'b0, 32'h0, 1'b0, 1'b1, 32'h00112223);
        step("sw_exec", AB | ADD);
        step("sw_mem_wait", REQ | WE | AS);
        step("sw_mem_done", REQ | WE | AS | PW, 1'b1);
        // BEQ taken
        step("beq_fetch", REQ, 1'b1, 32'h00000463);
        step("beq_decode", S_B);
        step("beq_exec", AA | AB | PW | PS, 1'b0, 32'h0, 1'b1);
        // JAL x1, 8
        step("jal_fetch", REQ, 1'b1, 32'h008000EF);
        step("jal_decode", S_J);
        step("jal_exec", AA | AB | ADD);
        step("jal_wb", RF | PW | W_PC4 | PS);
        // LUI x1, 0x12345
        step("lui_fetch", REQ, 1'b1, 32'h123450B7);
        step("lui_decode", S_U);
        step("lui_exec", 16'h0);
        step("lui_wb", RF | PW | W_IMM);
        // LW zero-wait
        step("lw_fetch", REQ, 1'b1, 32'h00002083);
        step("lw_decode", 16'h0);
        step("lw_exec", AB | ADD);
        step("lw_mem", REQ | AS, 1'b1);
        step("lw_wb", RF | PW | W_MEM);
        // 15 stalled FETCH cycles, ready on the 16th: no error, BEQ not taken
        for (int i = 0; i < 15; i++) step("fetch_stall", REQ);
        step("fetch_ready16", REQ, 1'b1, 32'h00000463);
        step("late_decode", S_B);
        step("late_exec", AA | AB | PW);
        // unlisted opcode
        step("ill_fetch", REQ, 1'b1, 32'hFFFFFFFF);
        step("ill_decode", 16'h0);
`ifdef ILLEGAL_TRAP_EN
        step("ill_err", IL);
        step("ill_err_hold", IL, 1'b1, 32'h00500093);
        rst_n = 1'b0;
        step("ill_reset", 16'h0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h13);
        rst_n = 1'b1;
`else
        step("ill_exec", 16'h0);
        step("ill_wb", PW);
`endif
        // LW interrupted by reset while stalled in MEM
        step("lwr_fetch", REQ, 1'b1, 32'h00002083);
        step("lwr_decode", 16'h0);
        step("lwr_exec", AB | ADD);
        step("lwr_mem", REQ | AS);
        rst_n = 1'b0;
        step("lwr_reset_in_mem", 16'h0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h13);
        rst_n = 1'b1;
        // 16 stalled FETCH cycles from release: timeout into ERR, which is terminal
        for (int i = 0; i < 16; i++) step("timeout_wait", REQ, 1'b0, 32'h0, 1'b0, 1'b1, 32'h13);
        step("timeout_err", BE);
        step("err_hold", BE, 1'b1, 32'h00500093);
        step("err_hold2", BE, 1'b1, 32'h00500093);
        repeat (2) @(posedge clk);
        n_cmp++;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_drain got %0d pending exp 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
